// File: rtl/sensors_avg_seq.sv
// sensors_avg_seq -- rounded average of paired height sensors.
//
// A frame of N_SENSORS readings is captured when in_valid/in_ready handshake
// in IDLE. Readings are paired as (i, i+N_SENSORS/2); a pair contributes to
// the average only if both readings are non-zero. Zero readings raise the
// matching fault bit. The sum is divided by the number of contributing
// readings with round-half-up using a restoring divider, one quotient bit per
// cycle. If no pair is valid, error is raised and height is 0.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   sensors    packed readings, sensor i at [i*WIDTH +: WIDTH]
//   in_valid   sensors holds a frame
//   in_ready   block can accept a frame (IDLE only)
//   height     rounded average height
//   fault      per-sensor zero-reading flags of the reported frame
//   error      no valid pair in the reported frame
//   out_valid  height/fault/error valid (DONE only)
//   out_ready  consumer accepts the result
module sensors_avg_seq #(
  parameter int N_SENSORS = 4,
  parameter int WIDTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_SENSORS*WIDTH-1:0] sensors,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           height,
  output logic [N_SENSORS-1:0]       fault,
  output logic                       error,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int SUMW = WIDTH + $clog2(N_SENSORS);
  localparam int HALF = N_SENSORS / 2;
  localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CW   = $clog2(SUMW + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, DONE} state_t;

  state_t                     state, state_nx;
  logic [N_SENSORS*WIDTH-1:0] frame;
  logic [SUMW-1:0]            sum, count;
  logic [SUMW-1:0]            quo, rem, dvs;
  logic [IW-1:0]              idx;
  logic [CW-1:0]              div_cnt;
  logic [N_SENSORS-1:0]       fault_acc;

  logic [WIDTH-1:0]           rd_a, rd_b;
  logic                       pair_ok;
  logic [SUMW:0]              shifted;
  logic [SUMW+1:0]            diff;
  logic                       borrow;
  logic [SUMW-1:0]            quo_nx;
  logic [SUMW-1:0]            rounded;
  logic                       div_last;
  logic                       unused_bits;

  // Current pair under accumulation.
  assign rd_a    = frame[int'(idx)*WIDTH +: WIDTH];
  assign rd_b    = frame[(int'(idx)+HALF)*WIDTH +: WIDTH];
  assign pair_ok = (|rd_a) && (|rd_b);

  // One restoring-division step: shift in the next dividend bit and try to
  // subtract the divisor; a borrow means the quotient bit is 0.
  assign shifted     = {rem, quo[SUMW-1]};
  assign diff        = {1'b0, shifted} - {2'b00, dvs};
  assign borrow      = diff[SUMW+1];
  assign quo_nx      = {quo[SUMW-2:0], ~borrow};
  assign unused_bits = diff[SUMW];

  // Adding count/2 before dividing gives round-half-up; the sum of
  // N_SENSORS readings plus N_SENSORS/2 always fits in SUMW bits.
  assign rounded  = sum + (count >> 1);
  assign div_last = (div_cnt == CW'(SUMW));

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (in_valid) state_nx = ACCUM;
      ACCUM: if (idx == IW'(HALF - 1)) state_nx = DIV;
      // First DIV cycle either short-circuits an empty frame or loads the
      // divider; the remaining SUMW cycles each produce one quotient bit.
      DIV:   if (((div_cnt == '0) && (count == '0)) || div_last) state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame     <= '0;
      sum       <= '0;
      count     <= '0;
      quo       <= '0;
      rem       <= '0;
      dvs       <= '0;
      idx       <= '0;
      div_cnt   <= '0;
      fault_acc <= '0;
      height    <= '0;
      fault     <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            frame     <= sensors;
            sum       <= '0;
            count     <= '0;
            idx       <= '0;
            div_cnt   <= '0;
            fault_acc <= '0;
          end
        end
        ACCUM: begin
          if (pair_ok) begin
            sum   <= sum + SUMW'(rd_a) + SUMW'(rd_b);
            count <= count + SUMW'(2);
          end else begin
            if (rd_a == '0) fault_acc[int'(idx)]      <= 1'b1;
            if (rd_b == '0) fault_acc[int'(idx)+HALF] <= 1'b1;
          end
          idx <= idx + 1'b1;
        end
        DIV: begin
          if (div_cnt == '0) begin
            if (count == '0) begin
              height <= '0;
              error  <= 1'b1;
              fault  <= fault_acc;
            end else begin
              quo     <= rounded;
              rem     <= '0;
              dvs     <= count;
              div_cnt <= CW'(1);
            end
          end else begin
            rem     <= borrow ? shifted[SUMW-1:0] : diff[SUMW-1:0];
            quo     <= quo_nx;
            div_cnt <= div_cnt + CW'(1);
            if (div_last) begin
              // Quotient never exceeds the largest reading, so it fits WIDTH.
              height <= quo_nx[WIDTH-1:0];
              error  <= 1'b0;
              fault  <= fault_acc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
